// File: rtl/cconv_ctrl.sv
// Control sequencer for the N-tap circular-convolution datapath: clears the banks,
// loads one coefficient set, streams N samples in, then rotates N results out.
module cconv_ctrl #(
    parameter int N    = 10,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [1:0]      coef_sel,
    input  logic            x_valid,
    output logic            x_ready,
    input  logic            y_ready,
    output logic            y_valid,
    output logic [IDXW-1:0] out_idx,
    output logic            busy,
    output logic            done,
    output logic            shift_r,
    output logic            mode_r,
    output logic            reset_r,
    output logic [1:0]      sel_h,
    output logic            ce_h,
    output logic            reset_h,
    output logic            reset_c,
    output logic            count_enb
);

    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD_H = 3'd2,
        FILL   = 3'd3,
        ROT    = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state, state_nx;
    logic [IDXW-1:0] fill_cnt, fill_nx;
    logic [IDXW-1:0] idx_q, idx_nx;
    logic [1:0]      sel_q, sel_nx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            fill_cnt <= '0;
            idx_q    <= '0;
            sel_q    <= '0;
        end else begin
            state    <= state_nx;
            fill_cnt <= fill_nx;
            idx_q    <= idx_nx;
            sel_q    <= sel_nx;
        end
    end

    // Registered index/select are forced to zero while reset is held so every
    // output is defined from the very first reset cycle.
    assign out_idx = reset ? idx_q : '0;
    assign sel_h   = reset ? sel_q : 2'd0;

    always_comb begin
        state_nx  = state;
        fill_nx   = fill_cnt;
        idx_nx    = idx_q;
        sel_nx    = sel_q;
        x_ready   = 1'b0;
        y_valid   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        shift_r   = 1'b0;
        mode_r    = 1'b0;
        reset_r   = 1'b0;
        ce_h      = 1'b0;
        reset_h   = 1'b0;
        reset_c   = 1'b0;
        count_enb = 1'b0;

        if (!reset) begin
            reset_r  = 1'b1;
            reset_h  = 1'b1;
            reset_c  = 1'b1;
            state_nx = IDLE;
        end else if (abort && state != IDLE) begin
            // Cancel: every strobe and handshake stays low this cycle.
            busy     = 1'b1;
            state_nx = IDLE;
            fill_nx  = '0;
            idx_nx   = '0;
        end else begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_nx   = coef_sel;
                        fill_nx  = '0;
                        idx_nx   = '0;
                        state_nx = CLEAR;
                    end
                end
                CLEAR: begin
                    reset_r  = 1'b1;
                    reset_h  = 1'b1;
                    reset_c  = 1'b1;
                    state_nx = LOAD_H;
                end
                LOAD_H: begin
                    ce_h     = 1'b1;
                    fill_nx  = '0;
                    state_nx = FILL;
                end
                FILL: begin
                    x_ready = 1'b1;
                    if (x_valid) begin
                        shift_r = 1'b1;
                        if (fill_cnt == LAST) begin
                            idx_nx   = '0;
                            state_nx = ROT;
                        end else begin
                            fill_nx = fill_cnt + 1'b1;
                        end
                    end
                end
                ROT: begin
                    // The last transfer still rotates, restoring the loaded order.
                    y_valid = 1'b1;
                    mode_r  = 1'b1;
                    if (y_ready) begin
                        shift_r   = 1'b1;
                        count_enb = 1'b1;
                        if (idx_q == LAST) begin
                            state_nx = DONE;
                        end else begin
                            idx_nx = idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cconv_ctrl.sv
// Directed bench for cconv_ctrl: a table for reset plus a nominal job, then
// hand-written sequences for bubbles, backpressure, abort, ignored start and mid-job reset.
module tb_cconv_ctrl;

    logic       clk;
    logic       reset, start, abort, x_valid, y_ready;
    logic [1:0] coef_sel;
    logic       x_ready, y_valid, busy, done, shift_r, mode_r, reset_r;
    logic       ce_h, reset_h, reset_c, count_enb;
    logic [3:0] out_idx;
    logic [1:0] sel_h;

    int checks = 0;
    int errors = 0;
    int shifts = 0;

    cconv_ctrl #(.N(10), .IDXW(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .coef_sel(coef_sel),
        .x_valid(x_valid), .x_ready(x_ready), .y_ready(y_ready), .y_valid(y_valid),
        .out_idx(out_idx), .busy(busy), .done(done), .shift_r(shift_r), .mode_r(mode_r),
        .reset_r(reset_r), .sel_h(sel_h), .ce_h(ce_h), .reset_h(reset_h),
        .reset_c(reset_c), .count_enb(count_enb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed layout: xr yv idx[3:0] busy done sh md rr sel[1:0] ce rh rc cnt
    function automatic logic [16:0] mk(input logic xr, yv, input logic [3:0] idx,
                                       input logic bz, dn, sh, md, rr, input logic [1:0] sel,
                                       input logic ce, rh, rc, cnt);
        return {xr, yv, idx, bz, dn, sh, md, rr, sel, ce, rh, rc, cnt};
    endfunction

    function automatic logic [16:0] e_rst();
        return mk(0, 0, 4'd0, 0, 0, 0, 0, 1, 2'd0, 0, 1, 1, 0);
    endfunction
    function automatic logic [16:0] e_idle(input logic [1:0] s);
        return mk(0, 0, 4'd0, 0, 0, 0, 0, 0, s, 0, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_clr(input logic [1:0] s);
        return mk(0, 0, 4'd0, 1, 0, 0, 0, 1, s, 0, 1, 1, 0);
    endfunction
    function automatic logic [16:0] e_ldh(input logic [1:0] s);
        return mk(0, 0, 4'd0, 1, 0, 0, 0, 0, s, 1, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_fill(input logic [1:0] s, input logic xv);
        return mk(1, 0, 4'd0, 1, 0, xv, 0, 0, s, 0, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_rot(input logic [1:0] s, input logic [3:0] i, input logic yr);
        return mk(0, 1, i, 1, 0, yr, 1, 0, s, 0, 0, 0, yr);
    endfunction
    function automatic logic [16:0] e_done(input logic [1:0] s);
        return mk(0, 0, 4'd0, 1, 1, 0, 0, 0, s, 0, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_abort(input logic [1:0] s);
        return mk(0, 0, 4'd0, 1, 0, 0, 0, 0, s, 0, 0, 0, 0);
    endfunction

    // Drive at the falling edge, compare 2 time units later, then step one cycle.
    task automatic cyc(input logic r, st, ab, input logic [1:0] cs, input logic xv, yr,
                       input logic [16:0] ex, input logic care_idx, input string nm);
        logic [16:0] got, mask;
        reset = r; start = st; abort = ab; coef_sel = cs; x_valid = xv; y_ready = yr;
        #2;
        got  = {x_ready, y_valid, out_idx, busy, done, shift_r, mode_r, reset_r,
                sel_h, ce_h, reset_h, reset_c, count_enb};
        mask = care_idx ? 17'h1FFFF : 17'h187FF;
        checks++;
        if (((got ^ ex) & mask) !== 17'd0) begin
            errors++;
            $display("FAIL %s: got %h expected %h (mask %h)", nm, got, ex, mask);
        end
        if (shift_r === 1'b1) shifts++;
        @(negedge clk);
    endtask

    typedef struct {
        logic        r, st, ab;
        logic [1:0]  cs;
        logic        xv, yr;
        logic [16:0] ex;
        logic        care;
    } vec_t;

    vec_t tbl[27];

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; coef_sel = 2'd0;
        x_valid = 1'b0; y_ready = 1'b0;

        // Reset two cycles, then a nominal job with coef_sel=2 (start = cycle 0 = row 2).
        tbl[0] = '{0, 0, 0, 2'd0, 1, 1, e_rst(), 1};
        tbl[1] = '{0, 0, 0, 2'd0, 1, 1, e_rst(), 1};
        tbl[2] = '{1, 1, 0, 2'd2, 1, 1, e_idle(2'd0), 1};
        tbl[3] = '{1, 0, 0, 2'd0, 1, 1, e_clr(2'd2), 0};
        tbl[4] = '{1, 0, 0, 2'd0, 1, 1, e_ldh(2'd2), 0};
        for (int k = 0; k < 10; k++) tbl[5 + k]  = '{1, 0, 0, 2'd0, 1, 1, e_fill(2'd2, 1'b1), 0};
        for (int k = 0; k < 10; k++) tbl[15 + k] = '{1, 0, 0, 2'd0, 1, 1, e_rot(2'd2, 4'(k), 1'b1), 1};
        tbl[25] = '{1, 0, 0, 2'd0, 1, 1, e_done(2'd2), 0};
        tbl[26] = '{1, 0, 0, 2'd0, 1, 1, e_idle(2'd2), 0};

        @(negedge clk);
        shifts = 0;
        for (int i = 0; i < 27; i++)
            cyc(tbl[i].r, tbl[i].st, tbl[i].ab, tbl[i].cs, tbl[i].xv, tbl[i].yr,
                tbl[i].ex, tbl[i].care, $sformatf("nominal_row%0d", i));
        checks++;
        if (shifts != 20) begin
            errors++;
            $display("FAIL nominal_shift_total: got %0d expected 20", shifts);
        end

        // Input bubbles, then output backpressure at out_idx=4.
        cyc(1, 1, 0, 2'd0, 0, 1, e_idle(2'd2), 0, "bub_start");
        cyc(1, 0, 0, 2'd0, 0, 1, e_clr(2'd0), 0, "bub_clear");
        cyc(1, 0, 0, 2'd0, 0, 1, e_ldh(2'd0), 0, "bub_load");
        shifts = 0;
        for (int k = 0; k < 19; k++)
            cyc(1, 0, 0, 2'd0, (k % 2 == 0), 1, e_fill(2'd0, (k % 2 == 0)), 0,
                $sformatf("bub_fill%0d", k));
        checks++;
        if (shifts != 10) begin
            errors++;
            $display("FAIL bub_shift_total: got %0d expected 10", shifts);
        end
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 0, 2'd0, 0, 1, e_rot(2'd0, 4'(i), 1'b1), 1, $sformatf("bp_rot%0d", i));
        for (int w = 0; w < 3; w++)
            cyc(1, 0, 0, 2'd0, 0, 0, e_rot(2'd0, 4'd4, 1'b0), 1, $sformatf("bp_hold%0d", w));
        for (int i = 4; i < 10; i++)
            cyc(1, 0, 0, 2'd0, 0, 1, e_rot(2'd0, 4'(i), 1'b1), 1, $sformatf("bp_rot%0d", i));
        cyc(1, 0, 0, 2'd0, 0, 1, e_done(2'd0), 0, "bp_done");
        cyc(1, 0, 0, 2'd0, 0, 1, e_idle(2'd0), 0, "bp_idle");

        // Abort in ROT at out_idx=6, competing with start/x_valid/y_ready.
        cyc(1, 1, 0, 2'd3, 1, 1, e_idle(2'd0), 0, "ab_start");
        cyc(1, 0, 0, 2'd0, 1, 1, e_clr(2'd3), 0, "ab_clear");
        cyc(1, 0, 0, 2'd0, 1, 1, e_ldh(2'd3), 0, "ab_load");
        for (int k = 0; k < 10; k++)
            cyc(1, 0, 0, 2'd0, 1, 1, e_fill(2'd3, 1'b1), 0, $sformatf("ab_fill%0d", k));
        for (int i = 0; i < 6; i++)
            cyc(1, 0, 0, 2'd0, 1, 1, e_rot(2'd3, 4'(i), 1'b1), 1, $sformatf("ab_rot%0d", i));
        cyc(1, 1, 1, 2'd1, 1, 1, e_abort(2'd3), 0, "ab_cycle");
        cyc(1, 0, 0, 2'd0, 1, 1, e_idle(2'd3), 0, "ab_idle");
        cyc(1, 0, 1, 2'd0, 1, 1, e_idle(2'd3), 0, "ab_in_idle");
        cyc(1, 0, 0, 2'd0, 1, 1, e_idle(2'd3), 0, "ab_in_idle_after");

        // Fresh job with coef_sel=1; start pulses in FILL and DONE must be ignored.
        cyc(1, 1, 0, 2'd1, 1, 1, e_idle(2'd3), 0, "j1_start");
        cyc(1, 0, 0, 2'd0, 1, 1, e_clr(2'd1), 0, "j1_clear");
        cyc(1, 0, 0, 2'd0, 1, 1, e_ldh(2'd1), 0, "j1_load");
        for (int k = 0; k < 10; k++)
            cyc(1, (k == 4), 0, 2'd2, 1, 1, e_fill(2'd1, 1'b1), 0, $sformatf("j1_fill%0d", k));
        for (int i = 0; i < 10; i++)
            cyc(1, 0, 0, 2'd0, 1, 1, e_rot(2'd1, 4'(i), 1'b1), 1, $sformatf("j1_rot%0d", i));
        cyc(1, 1, 0, 2'd2, 1, 1, e_done(2'd1), 0, "j1_done_start");
        cyc(1, 0, 0, 2'd0, 1, 1, e_idle(2'd1), 0, "j1_no_restart");
        cyc(1, 0, 0, 2'd0, 1, 1, e_idle(2'd1), 0, "j1_still_idle");

        // Reset asserted mid-FILL after five accepted samples.
        cyc(1, 1, 0, 2'd2, 1, 1, e_idle(2'd1), 0, "mr_start");
        cyc(1, 0, 0, 2'd0, 1, 1, e_clr(2'd2), 0, "mr_clear");
        cyc(1, 0, 0, 2'd0, 1, 1, e_ldh(2'd2), 0, "mr_load");
        for (int k = 0; k < 5; k++)
            cyc(1, 0, 0, 2'd0, 1, 1, e_fill(2'd2, 1'b1), 0, $sformatf("mr_fill%0d", k));
        cyc(0, 0, 0, 2'd0, 1, 1, e_rst(), 1, "mr_reset0");
        cyc(0, 0, 0, 2'd0, 1, 1, e_rst(), 1, "mr_reset1");
        cyc(1, 0, 0, 2'd0, 1, 1, e_idle(2'd0), 1, "mr_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
